addsub_serial: RTL and testbench

- Parametrised, digit-serial signed/unsigned add/subtract unit for the MIPS datapath. Next generation of the fixed 32-bit subtractor.
- Processes DIGIT bits per clock, LSB first, over WIDTH/DIGIT cycles.
- Computes a+b or a-b and reports carry, signed overflow and zero.
- Uses a start/busy/done handshake so multi-cycle ALU ops can share one narrow adder.

---
 rtl/addsub_serial.sv | 128 ++++++++++++
 tb/tb_addsub_serial.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSB first,
// with carry, signed-overflow and zero flags and a start/busy/done handshake.
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_n;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    base;
  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT:0]   sum;

  assign last = (cnt == CW'(N - 1));
  assign base = IW'(32'(cnt) * DIGIT);
  assign a_d  = a_r[base +: DIGIT];
  assign b_d  = b_r[base +: DIGIT];
  assign sum  = {1'b0, a_d} + {1'b0, b_d} + (DIGIT + 1)'(carry);

  always_comb begin
    res_n = result;
    res_n[base +: DIGIT] = sum[DIGIT-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // b is stored pre-inverted for subtract so RUN is a plain add
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b1;
    end else if (load) begin
      a_r    <= a;
      b_r    <= sub ? ~b : b;
      carry  <= sub;
      cnt    <= '0;
      result <= '0;
    end else if (step) begin
      result <= res_n;
      carry  <= sum[DIGIT];
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) begin
        cout <= sum[DIGIT];
        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                (sum[DIGIT-1] != a_r[WIDTH-1]);
        zero <= (res_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: three instances (DIGIT 8, 1, 32)
// share stimulus; results, flags, latency and handshake are checked.
module tb_addsub_serial;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy   [3];
  logic        done   [3];
  logic [31:0] result [3];
  logic        cout   [3];
  logic        ovf    [3];
  logic        zero   [3];

  int errors = 0;
  int checks = 0;
  int lat_exp [3] = '{4, 32, 1};

  addsub_serial #(.WIDTH(32), .DIGIT(8)) u8 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy[0]), .done(done[0]), .result(result[0]),
    .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  addsub_serial #(.WIDTH(32), .DIGIT(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy[1]), .done(done[1]), .result(result[1]),
    .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  addsub_serial #(.WIDTH(32), .DIGIT(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy[2]), .done(done[2]), .result(result[2]),
    .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {zero, ovf, cout, result} from plain two's-complement arithmetic
  function automatic logic [34:0] model(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic s);
    logic [31:0] yy;
    logic [32:0] t;
    logic        v;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + 33'(s);
    v  = (x[31] == yy[31]) && (t[31] != x[31]);
    return {t[31:0] == 32'd0, v, t[32], t[31:0]};
  endfunction

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [34:0] exp,
                        input string tag);
    int          lat [3];
    logic [34:0] got [3];
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      got[i] = '0;
    end
    a = ta;
    b = tb_;
    sub = ts;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = ~ts;
    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (done[i] && lat[i] == 0) begin
          lat[i] = k;
          got[i] = {zero[i], ovf[i], cout[i], result[i]};
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s d%0d lat", tag, i), 64'(lat[i]),
            64'(lat_exp[i]));
      check($sformatf("%s d%0d res", tag, i), 64'(got[i]), 64'(exp));
    end
  endtask

  initial begin
    int          cnt;
    int          dk;
    logic [31:0] r;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset d%0d", i),
            64'({busy[i], done[i], zero[i], ovf[i], cout[i], result[i]}),
            64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0}));
    end
    reset = 1'b0;
    tick();

    run_op(32'd7, 32'd6, 1'b1, {1'b0, 1'b0, 1'b1, 32'h1}, "sub 7-6");
    run_op(32'hFFFFFFF9, 32'd6, 1'b1,
           {1'b0, 1'b0, 1'b1, 32'hFFFFFFF3}, "sub -7-6");
    run_op(32'd6, 32'd7, 1'b1,
           {1'b0, 1'b0, 1'b0, 32'hFFFFFFFF}, "borrow 6-7");
    run_op(32'h20, 32'h20, 1'b1, {1'b1, 1'b0, 1'b1, 32'h0}, "zero");
    run_op(32'h7FFFFFFF, 32'd1, 1'b0,
           {1'b0, 1'b1, 1'b0, 32'h80000000}, "ovf add");
    run_op(32'h80000000, 32'd1, 1'b1,
           {1'b0, 1'b1, 1'b1, 32'h7FFFFFFF}, "ovf sub");
    run_op(32'hFFFFFFF9, 32'hFFFFFFFA, 1'b0,
           {1'b0, 1'b0, 1'b1, 32'hFFFFFFF3}, "add neg");

    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (n % 8 == 0) rb = ra;
      run_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", n));
    end

    // extra starts during RUN must be ignored
    a = 32'd5;
    b = 32'd3;
    sub = 1'b1;
    start = 1'b1;
    tick();
    cnt = 0;
    dk = 0;
    r = '0;
    for (int k = 1; k <= 10; k++) begin
      start = (k == 2 || k == 3);
      if (start) begin
        a = 32'd100;
        b = 32'd1;
        sub = 1'b0;
      end
      tick();
      if (done[0]) begin
        cnt++;
        dk = k;
        r = result[0];
      end
    end
    start = 1'b0;
    check("ignore start count", 64'(cnt), 64'd1);
    check("ignore start lat", 64'(dk), 64'd4);
    check("ignore start res", 64'(r), 64'd2);

    // back-to-back start in the DONE cycle
    a = 32'd7;
    b = 32'd6;
    sub = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dk = 0;
    r = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done[0] && dk == 0) begin
        dk = k;
        r = result[0];
        break;
      end
    end
    check("b2b first lat", 64'(dk), 64'd4);
    check("b2b first res", 64'(r), 64'd1);
    a = 32'd10;
    b = 32'd4;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    dk = 0;
    r = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done[0] && dk == 0) begin
        dk = k;
        r = result[0];
      end
    end
    check("b2b second lat", 64'(dk), 64'd4);
    check("b2b second res", 64'(r), 64'd14);

    // asynchronous reset two cycles into an operation
    a = 32'd5;
    b = 32'd3;
    sub = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1 reset = 1'b1;
    #1;
    check("async reset",
          64'({busy[0], done[0], zero[0], result[0]}),
          64'({1'b0, 1'b0, 1'b1, 32'd0}));
    reset = 1'b0;
    tick();
    run_op(32'd5, 32'd3, 1'b0, {1'b0, 1'b0, 1'b0, 32'd8}, "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
